// File: rtl/trig_mod_v3.sv
// Level/edge trigger generator for the ADC capture path: signed conversion, Schmitt
// comparator with hysteresis, edge selection, arm/single-shot, holdoff and trigger counter.
module trig_mod_v3 #(
   parameter int DW            = 14,
   parameter int OFFSET_BINARY = 1,
   parameter int HO_W          = 16,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DW-1:0]    ain,
   input  logic [DW-1:0]    trg_level,
   input  logic [DW-2:0]    hyst,
   input  logic [1:0]       mode,
   input  logic [HO_W-1:0]  holdoff,
   input  logic             single,
   input  logic             arm,
   input  logic             disarm,
   output logic             trg,
   output logic             armed,
   output logic [CNT_W-1:0] trg_count
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      HOLDOFF = 2'd2
   } state_t;

   state_t            state_r, state_next_s;
   logic [DW-1:0]     conv_s;
   logic [DW-1:0]     sample_r;
   logic signed [DW:0] sample_ext_s, upper_s, lower_s;
   logic              ge_upper_s, le_lower_s;
   logic              hi_r, hi_next_s, primed_r;
   logic              rise_r, fall_r, event_sel_s;
   logic [HO_W-1:0]   ho_cnt_r, ho_cnt_next_s;
   logic [CNT_W-1:0]  count_r, count_next_s;
   logic              trg_r, trg_next_s, armed_r;

   // Offset-binary to two's complement: only the MSB differs.
   always_comb begin
      conv_s = ain;
      if (OFFSET_BINARY != 0) begin
         conv_s[DW-1] = ~ain[DW-1];
      end else begin
         conv_s[DW-1] = ain[DW-1];
      end
   end

   // Thresholds widened by one bit so level +/- hysteresis never wraps.
   assign sample_ext_s = $signed({sample_r[DW-1], sample_r});
   assign upper_s      = $signed({trg_level[DW-1], trg_level}) + $signed({2'b00, hyst});
   assign lower_s      = $signed({trg_level[DW-1], trg_level}) - $signed({2'b00, hyst});
   assign ge_upper_s   = (sample_ext_s >= upper_s);
   assign le_lower_s   = (sample_ext_s <= lower_s);

   // Schmitt decision: outside the band forces the state, inside holds it.
   always_comb begin
      hi_next_s = hi_r;
      if (ge_upper_s) begin
         hi_next_s = 1'b1;
      end else if (le_lower_s) begin
         hi_next_s = 1'b0;
      end else begin
         hi_next_s = hi_r;
      end
   end

   // Sample, Schmitt state and edge-event pipeline registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_r <= {DW{1'b0}};
         hi_r     <= 1'b0;
         primed_r <= 1'b0;
         rise_r   <= 1'b0;
         fall_r   <= 1'b0;
      end else begin
         sample_r <= conv_s;
         hi_r     <= hi_next_s;
         primed_r <= primed_r | ge_upper_s | le_lower_s;
         rise_r   <= primed_r & ~hi_r & hi_next_s;
         fall_r   <= primed_r & hi_r & ~hi_next_s;
      end
   end

   // Edge selection by mode.
   always_comb begin
      event_sel_s = 1'b0;
      case (mode)
         2'b00:   event_sel_s = rise_r;
         2'b01:   event_sel_s = fall_r;
         2'b10:   event_sel_s = rise_r | fall_r;
         default: event_sel_s = 1'b0;
      endcase
   end

   // Arm/trigger/holdoff FSM next-state and output decode.
   always_comb begin
      state_next_s  = state_r;
      trg_next_s    = 1'b0;
      ho_cnt_next_s = ho_cnt_r;
      count_next_s  = count_r;
      if (disarm) begin
         state_next_s  = IDLE;
         ho_cnt_next_s = {HO_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (arm) begin
                  state_next_s = ARMED;
                  count_next_s = {CNT_W{1'b0}};
               end else begin
                  state_next_s = IDLE;
               end
            end
            ARMED: begin
               if (event_sel_s) begin
                  trg_next_s = 1'b1;
                  if (count_r != {CNT_W{1'b1}}) begin
                     count_next_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                  end else begin
                     count_next_s = count_r;
                  end
                  if (single) begin
                     state_next_s = IDLE;
                  end else if (holdoff == {HO_W{1'b0}}) begin
                     state_next_s = ARMED;
                  end else begin
                     state_next_s  = HOLDOFF;
                     ho_cnt_next_s = holdoff;
                  end
               end else begin
                  state_next_s = ARMED;
               end
            end
            HOLDOFF: begin
               // Leaving on count 1 blocks exactly 'holdoff' evaluations after the trigger.
               if (ho_cnt_r <= {{(HO_W-1){1'b0}}, 1'b1}) begin
                  state_next_s  = ARMED;
                  ho_cnt_next_s = {HO_W{1'b0}};
               end else begin
                  ho_cnt_next_s = ho_cnt_r - {{(HO_W-1){1'b0}}, 1'b1};
               end
            end
            default: begin
               state_next_s  = IDLE;
               ho_cnt_next_s = {HO_W{1'b0}};
            end
         endcase
      end
   end

   // FSM state, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         ho_cnt_r <= {HO_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
         trg_r    <= 1'b0;
         armed_r  <= 1'b0;
      end else begin
         state_r  <= state_next_s;
         ho_cnt_r <= ho_cnt_next_s;
         count_r  <= count_next_s;
         trg_r    <= trg_next_s;
         armed_r  <= (state_next_s != IDLE);
      end
   end

   assign trg       = trg_r;
   assign armed     = armed_r;
   assign trg_count = count_r;

endmodule

// File: tb/tb_trig_mod_v3.sv
// Self-checking bench for trig_mod_v3: cycle scoreboard against a behavioural model
// plus scenario-level checks of trigger timing, counts and control corner cases.
module tb_trig_mod_v3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [13:0] ain, trg_level;
   logic [12:0] hyst;
   logic [1:0]  mode;
   logic [15:0] holdoff;
   logic        single, arm, disarm;
   logic        trg, armed;
   logic [15:0] trg_count;

   int errors = 0;
   int checks = 0;
   int n_trg  = 0;
   logic [17:0] exp_q[$];

   int m_s, m_st, m_cnt, m_count;
   bit m_hi, m_primed, m_rq, m_fq, m_trg;

   always #5 clk = ~clk;

   trig_mod_v3 dut (
      .clk(clk), .rst_n(rst_n), .ain(ain), .trg_level(trg_level), .hyst(hyst),
      .mode(mode), .holdoff(holdoff), .single(single), .arm(arm), .disarm(disarm),
      .trg(trg), .armed(armed), .trg_count(trg_count)
   );

   task automatic set_s(input int v);
      ain = 14'(v + 8192);
   endtask

   task automatic model_reset();
      m_s = 0; m_st = 0; m_cnt = 0; m_count = 0;
      m_hi = 0; m_primed = 0; m_rq = 0; m_fq = 0; m_trg = 0;
   endtask

   // Behavioural model of one rising edge, using the inputs currently driven.
   task automatic model_step();
      int u, l;
      bit ev, ge, le, hn;
      u = int'($signed(trg_level)) + int'(hyst);
      l = int'($signed(trg_level)) - int'(hyst);
      case (mode)
         2'd0:    ev = m_rq;
         2'd1:    ev = m_fq;
         2'd2:    ev = m_rq | m_fq;
         default: ev = 1'b0;
      endcase
      m_trg = 1'b0;
      if (disarm) begin
         m_st = 0; m_cnt = 0;
      end else if (m_st == 0) begin
         if (arm) begin m_st = 1; m_count = 0; end
      end else if (m_st == 1) begin
         if (ev) begin
            m_trg = 1'b1;
            if (m_count < 65535) m_count++;
            if (single) m_st = 0;
            else if (holdoff != 16'd0) begin m_st = 2; m_cnt = int'(holdoff); end
         end
      end else begin
         if (m_cnt <= 1) begin m_st = 1; m_cnt = 0; end
         else m_cnt--;
      end
      ge = (m_s >= u);
      le = (m_s <= l);
      hn = ge ? 1'b1 : (le ? 1'b0 : m_hi);
      m_rq = m_primed & !m_hi & hn;
      m_fq = m_primed & m_hi & !hn;
      m_hi = hn;
      m_primed = m_primed | ge | le;
      m_s = int'(ain) - 8192;
   endtask

   // One clock: push model expectation, clock the DUT, pop and compare at negedge.
   task automatic cyc();
      logic [17:0] e;
      model_step();
      exp_q.push_back({m_trg, (m_st != 0), 16'(m_count)});
      @(posedge clk);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (trg !== e[17]) begin
         errors++; $display("FAIL sb_trg t=%0t got=%b exp=%b", $time, trg, e[17]);
      end
      checks++;
      if (armed !== e[16]) begin
         errors++; $display("FAIL sb_armed t=%0t got=%b exp=%b", $time, armed, e[16]);
      end
      checks++;
      if (trg_count !== e[15:0]) begin
         errors++; $display("FAIL sb_count t=%0t got=%0d exp=%0d", $time, trg_count, e[15:0]);
      end
      if (trg === 1'b1) n_trg++;
   endtask

   task automatic pulse_arm();
      arm = 1'b1; cyc(); arm = 1'b0;
   endtask

   task automatic pulse_disarm();
      disarm = 1'b1; cyc(); disarm = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++;
      if (trg !== 1'b0 || armed !== 1'b0 || trg_count !== 16'd0) begin
         errors++; $display("FAIL reset_vals got=%b/%b/%0d exp=0/0/0", trg, armed, trg_count);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_rising();
      pulse_arm();
      for (int i = 0; i < 4; i++) cyc();
      set_s(600);
      cyc();
      checks++;
      if (trg !== 1'b0) begin errors++; $display("FAIL rise_k got=%b exp=0", trg); end
      cyc();
      checks++;
      if (trg !== 1'b0) begin errors++; $display("FAIL rise_k1 got=%b exp=0", trg); end
      cyc();
      checks++;
      if (trg !== 1'b1) begin errors++; $display("FAIL rise_k2 got=%b exp=1", trg); end
      cyc();
      checks++;
      if (trg !== 1'b0) begin errors++; $display("FAIL rise_k3 got=%b exp=0", trg); end
      checks++;
      if (trg_count !== 16'd1 || armed !== 1'b1) begin
         errors++; $display("FAIL rise_state got=%0d/%b exp=1/1", trg_count, armed);
      end
   endtask

   task automatic test_hysteresis();
      n_trg = 0;
      for (int i = 0; i < 20; i++) begin
         set_s((i % 2) ? 530 : 510);
         cyc();
      end
      checks++;
      if (n_trg !== 0 || trg_count !== 16'd1) begin
         errors++; $display("FAIL hyst_noise got=%0d trg count=%0d exp=0 count=1", n_trg, trg_count);
      end
   endtask

   task automatic test_holdoff();
      int last = -1;
      holdoff = 16'd10;
      pulse_disarm();
      pulse_arm();
      n_trg = 0;
      for (int i = 0; i < 64; i++) begin
         set_s(((i / 4) % 2) ? 600 : 400);
         cyc();
         if (trg === 1'b1) begin
            if (last >= 0) begin
               checks++;
               if (i - last != 16) begin
                  errors++; $display("FAIL holdoff_period got=%0d exp=16", i - last);
               end
            end
            last = i;
         end
      end
      checks++;
      if (n_trg !== 4 || trg_count !== 16'd4) begin
         errors++; $display("FAIL holdoff_count got=%0d/%0d exp=4/4", n_trg, trg_count);
      end
   endtask

   task automatic test_both_single();
      holdoff = 16'd0;
      mode = 2'b10;
      pulse_disarm();
      pulse_arm();
      n_trg = 0;
      for (int i = 0; i < 32; i++) begin
         set_s(((i / 4) % 2) ? 600 : 400);
         cyc();
      end
      checks++;
      if (n_trg !== 8) begin errors++; $display("FAIL both_edges got=%0d exp=8", n_trg); end
      single = 1'b1;
      pulse_disarm();
      pulse_arm();
      n_trg = 0;
      for (int i = 0; i < 16; i++) begin
         set_s(((i / 4) % 2) ? 600 : 400);
         cyc();
      end
      checks++;
      if (n_trg !== 1 || armed !== 1'b0 || trg_count !== 16'd1) begin
         errors++; $display("FAIL single_shot got=%0d/%b/%0d exp=1/0/1", n_trg, armed, trg_count);
      end
      single = 1'b0;
   endtask

   task automatic test_control();
      mode = 2'b00;
      pulse_disarm();
      set_s(600);
      for (int i = 0; i < 3; i++) cyc();
      pulse_arm();
      n_trg = 0;
      for (int i = 0; i < 10; i++) cyc();
      checks++;
      if (n_trg !== 0 || armed !== 1'b1) begin
         errors++; $display("FAIL arm_high got=%0d/%b exp=0/1", n_trg, armed);
      end
      pulse_disarm();
      arm = 1'b1; disarm = 1'b1;
      cyc();
      arm = 1'b0; disarm = 1'b0;
      cyc();
      checks++;
      if (armed !== 1'b0) begin errors++; $display("FAIL arm_disarm got=%b exp=0", armed); end
      mode = 2'b11;
      pulse_arm();
      n_trg = 0;
      for (int i = 0; i < 50; i++) begin
         set_s((i % 2) ? 600 : 400);
         cyc();
      end
      checks++;
      if (n_trg !== 0 || armed !== 1'b1 || trg_count !== 16'd0) begin
         errors++; $display("FAIL mode_off got=%0d/%b/%0d exp=0/1/0", n_trg, armed, trg_count);
      end
   endtask

   task automatic test_reset_mid();
      mode = 2'b00;
      holdoff = 16'd20;
      pulse_disarm();
      pulse_arm();
      set_s(400);
      for (int i = 0; i < 3; i++) cyc();
      set_s(600);
      for (int i = 0; i < 7; i++) cyc();
      checks++;
      if (armed !== 1'b1 || trg_count !== 16'd1) begin
         errors++; $display("FAIL pre_reset got=%b/%0d exp=1/1", armed, trg_count);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (trg !== 1'b0 || armed !== 1'b0 || trg_count !== 16'd0) begin
         errors++; $display("FAIL async_reset got=%b/%b/%0d exp=0/0/0", trg, armed, trg_count);
      end
      model_reset();
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      holdoff = 16'd0;
      n_trg = 0;
      set_s(400);
      for (int i = 0; i < 3; i++) cyc();
      set_s(600);
      for (int i = 0; i < 4; i++) cyc();
      checks++;
      if (n_trg !== 0 || trg_count !== 16'd0) begin
         errors++; $display("FAIL no_arm got=%0d/%0d exp=0/0", n_trg, trg_count);
      end
      pulse_arm();
      set_s(400);
      for (int i = 0; i < 3; i++) cyc();
      set_s(600);
      for (int i = 0; i < 4; i++) cyc();
      checks++;
      if (n_trg !== 1 || trg_count !== 16'd1) begin
         errors++; $display("FAIL rearm got=%0d/%0d exp=1/1", n_trg, trg_count);
      end
   endtask

   initial begin
      trg_level = 14'd500;
      hyst      = 13'd20;
      mode      = 2'b00;
      holdoff   = 16'd0;
      single    = 1'b0;
      arm       = 1'b0;
      disarm    = 1'b0;
      set_s(400);
      model_reset();
      test_reset();
      test_rising();
      test_hysteresis();
      test_holdoff();
      test_both_single();
      test_control();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
